mccoy_instr_feeder: RTL and testbench
=====================================

# mccoy_instr_feeder

Program buffer and instruction sequencer sitting directly upstream of the McCoy core's 6-bit instruction input. Software (or a bench) loads a short program word by word through a valid/ready port. On `start` the block replays the program to the core, one registered instruction per cycle. The core may redirect the fetch address for taken branches/jumps, and the block reports completion.

## Interface
- `DEPTH`, 16: program buffer entries (power of two).
- `AW`, 4: address width, log2(DEPTH).
- `NOP_INSTR`, 6'b000000: value driven on `instr` whenever `instr_valid` is low.

- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_valid`  in  1  program word offered.
- `load_data`  in  6  instruction word, McCoy encoding.
- `load_ready`  out  1  word accepted on edge when valid&ready.
- `start`  in  1  begin replay from address 0.
- `halt`  in  1  stall replay while high.
- `clear`  in  1  discard program, return to IDLE.
- `redirect_valid`  in  1  core requests fetch redirect.
- `redirect_addr`  in  AW  redirect target.
- `instr`  out  6  instruction to core (registered).
- `instr_valid`  out  1  `instr` is live this cycle.
- `pc`  out  AW  address of next fetch.
- `prog_len`  out  AW+1  number of words loaded (0..DEPTH).
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.

## Operation
- States: IDLE, RUN, DONE. Reset and `clear` (any state, highest priority after reset) → IDLE, `prog_len`=0, `pc`=0, `instr`=NOP_INSTR, `instr_valid`=0, `busy`=0, `done`=0, `load_ready`=1.
- IDLE: `load_ready` = (`prog_len` < DEPTH). Accepted word written at address `prog_len`, `prog_len` += 1. Full: `load_ready`=0, `load_valid` ignored.
- IDLE + `start`: if effective length (including a word accepted the same edge) > 0 → RUN with `pc`=0; else ignored.
- RUN, `halt` low: edge issues `instr`←mem[`pc`], `instr_valid`←1, then next `pc`:
  - `redirect_valid` and `redirect_addr` < `prog_len` → `redirect_addr`;
  - `redirect_valid` and `redirect_addr` ≥ `prog_len` → state DONE;
  - else `pc` = `prog_len`−1 → DONE; else `pc`+1.
- RUN, `halt` high: `pc` holds, `instr_valid`←0, `instr`←NOP_INSTR; `redirect_valid` ignored (halt wins).
- DONE: `instr_valid`←0, `done`=1, program retained; `start` → RUN from `pc`=0; `load_valid` ignored (`load_ready`=0 outside IDLE).
- `start` ignored in RUN.
- Arithmetic: `pc` increments modulo DEPTH; `prog_len` saturates at DEPTH.

## Timing
- Load: one word per cycle at full throughput.
- `start` sampled at edge k → `busy` after k; mem[0] on `instr` after edge k+1 (one-cycle fetch latency).
- Redirect sampled at edge j (while mem[p] being issued on j): mem[p] still issued; mem[target] appears after edge j+1. One-instruction shadow, no squash.
- Last word issued at edge m → `done`=1 and `instr_valid`=0 after edge m+1.
- `halt` asserted at edge h → `instr_valid`=0 after h; deasserted at h' → replay resumes at held `pc` after h'.

## Configuration
- `FEEDER_LOOP_EN` defined: after issuing address `prog_len`−1 (no redirect), `pc` wraps to 0 and stays in RUN; out-of-range redirect also wraps to 0; DONE reachable only by never (exit via `clear`/reset). `done` tied 0.
- Undefined: behaviour as in Operation (end of program → DONE).

## Test plan
- Reset: assert `reset` 1 cycle → `instr`=000000, `instr_valid`=0, `prog_len`=0, `load_ready`=1, `busy`=`done`=0.
- Load 011001, 010110, 100001, 010100, start → `instr` sequence 011001, 010110, 100001, 010100 on 4 consecutive cycles beginning 2 edges after start, `done`=1 on the following cycle.
- Fill 16 words → `load_ready`=0, 17th `load_valid` ignored, `prog_len`=16.
- 6-word program, `redirect_valid` with `redirect_addr`=1 while `pc`=3 → issued addresses 0,1,2,3,1,2,3,4,5 then DONE; `redirect_addr`=7 instead → DONE after address 3 issued.
- `halt` high for 3 cycles mid-run → `instr_valid`=0 for 3 cycles, `pc` unchanged, sequence resumes with no skipped or repeated word; `clear` mid-run → IDLE, `prog_len`=0 next cycle.
- `FEEDER_LOOP_EN`, 3-word program → addresses 0,1,2,0,1,2… continuously, `done` never 1.

Source files
------------

// File: rtl/mccoy_instr_feeder.sv
// mccoy_instr_feeder: program buffer and replay sequencer feeding the McCoy core's 6-bit instruction port.
// Latency: start -> busy next cycle, mem[0] on instr one cycle later; one instruction per cycle, redirect has a one-instruction shadow.
// Backpressure: load_ready only in IDLE and while not full; halt stalls replay with pc held and instr_valid low.
// Build option: define FEEDER_LOOP_EN to replay the program endlessly (end of program and out-of-range redirect wrap to 0, done tied low).
module mccoy_instr_feeder #(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter logic [5:0] NOP_INSTR = 6'b000000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_valid,
  input  logic [5:0]    i_load_data,
  output logic          o_load_ready,
  input  logic          i_start,
  input  logic          i_halt,
  input  logic          i_clear,
  input  logic          i_redirect_valid,
  input  logic [AW-1:0] i_redirect_addr,
  output logic [5:0]    o_instr,
  output logic          o_instr_valid,
  output logic [AW-1:0] o_pc,
  output logic [AW:0]   o_prog_len,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [5:0]    r_mem [DEPTH];
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_prog_len;
  logic [5:0]    r_instr;
  logic          r_instr_valid;

  logic          w_load_ready;
  logic          w_load_fire;
  logic          w_last;
  logic          w_redir_ok;
  logic [AW-1:0] w_pc_inc;

  // Words are only accepted while idle and the buffer has room.
  assign w_load_ready = (r_state == ST_IDLE) && (r_prog_len < LP_DEPTH);
  assign w_load_fire  = i_load_valid && w_load_ready;
  // The word being issued is the final one of the program.
  assign w_last       = ({1'b0, r_pc} == (r_prog_len - 1'b1));
  // A redirect is honoured only if it lands inside the loaded program.
  assign w_redir_ok   = ({1'b0, i_redirect_addr} < r_prog_len);
  assign w_pc_inc     = r_pc + 1'b1;

  // Program storage: accepted word lands at the current length; contents survive clear (length gates use).
  always_ff @(posedge i_clk) begin
    if (w_load_fire && !i_reset && !i_clear) begin
      r_mem[r_prog_len[AW-1:0]] <= i_load_data;
    end
  end

  // Sequencer FSM: load in IDLE, replay one word per cycle in RUN, park in DONE.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_prog_len    <= '0;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
    end else begin
      // Nothing is issued unless RUN issues below.
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load_fire) begin
            r_prog_len <= r_prog_len + 1'b1;
          end
          // A word accepted on the start edge counts toward the length.
          if (i_start && (w_load_fire || (r_prog_len != '0))) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
          end
        end
        ST_RUN: begin
          // Halt wins over redirect: pc holds and the output stays NOP.
          if (!i_halt) begin
            r_instr       <= r_mem[r_pc];
            r_instr_valid <= 1'b1;
            if (i_redirect_valid && w_redir_ok) begin
              r_pc <= i_redirect_addr;
            end else if (i_redirect_valid || w_last) begin
`ifdef FEEDER_LOOP_EN
              r_pc <= '0;
`else
              r_state <= ST_DONE;
`endif
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end
        ST_DONE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_load_ready  = w_load_ready;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;
  assign o_prog_len    = r_prog_len;
  assign o_busy        = (r_state == ST_RUN);
`ifdef FEEDER_LOOP_EN
  assign o_done        = 1'b0;
`else
  assign o_done        = (r_state == ST_DONE);
`endif

endmodule

// File: tb/tb_mccoy_instr_feeder.sv
// Bench for mccoy_instr_feeder: directed scenarios plus randomized replay checked against a trace-level model.
module tb_mccoy_instr_feeder;

`ifdef FEEDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, load_valid, start, halt, clear, redirect_valid;
  logic [5:0] load_data;
  logic [3:0] redirect_addr;
  logic       load_ready, instr_valid, busy, done;
  logic [5:0] instr;
  logic [3:0] pc;
  logic [4:0] prog_len;

  logic [5:0] prog [16];
  logic [5:0] got [$];
  int n_cmp = 0;
  int n_err = 0;

  mccoy_instr_feeder dut (
    .i_clk(clk), .i_reset(reset),
    .i_load_valid(load_valid), .i_load_data(load_data), .o_load_ready(load_ready),
    .i_start(start), .i_halt(halt), .i_clear(clear),
    .i_redirect_valid(redirect_valid), .i_redirect_addr(redirect_addr),
    .o_instr(instr), .o_instr_valid(instr_valid), .o_pc(pc),
    .o_prog_len(prog_len), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; load_valid = 0; load_data = 0; start = 0; halt = 0; clear = 0;
    redirect_valid = 0; redirect_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic load_words(input int n, input bit start_last);
    for (int i = 0; i < n; i++) begin
      load_valid = 1;
      load_data  = prog[i];
      start      = start_last && (i == n - 1);
      step();
    end
    load_valid = 0;
    start      = 0;
  endtask

  task automatic kick();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic run_issue(input int n, input int rc, input logic [3:0] ra);
    got.delete();
    for (int c = 0; c < n; c++) begin
      redirect_valid = (c == rc);
      redirect_addr  = ra;
      step();
      if (instr_valid) got.push_back(instr);
    end
    redirect_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; load_valid = 1; load_data = 6'h2a; start = 1;
    step();
    idle_inputs();
    n_cmp++; if (instr !== 6'h00) begin n_err++; $display("FAIL reset_instr got=%b exp=000000", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    n_cmp++; if (prog_len !== 5'd0) begin n_err++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (pc !== 4'd0) begin n_err++; $display("FAIL reset_pc got=%0d exp=0", pc); end
  endtask

  task automatic test_replay();
    prog[0] = 6'b011001; prog[1] = 6'b010110; prog[2] = 6'b100001; prog[3] = 6'b010100;
    do_reset();
    load_words(4, 0);
    n_cmp++; if (prog_len !== 5'd4) begin n_err++; $display("FAIL replay_len got=%0d exp=4", prog_len); end
    kick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL replay_busy got=%b exp=1", busy); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL replay_latency got=%b exp=0", instr_valid); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL replay_load_ready got=%b exp=0", load_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== prog[i]) begin
        n_err++; $display("FAIL replay_word%0d got=%b/%b exp=1/%b", i, instr_valid, instr, prog[i]);
      end
    end
    step();
`ifdef FEEDER_LOOP_EN
    n_cmp++; if (instr !== prog[0] || done !== 1'b0) begin n_err++; $display("FAIL replay_wrap got=%b done=%b exp=%b done=0", instr, done, prog[0]); end
`else
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL replay_done got=%b exp=1", done); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL replay_end_valid got=%b exp=0", instr_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL replay_end_busy got=%b exp=0", busy); end
    // Restart from DONE replays from address 0.
    kick();
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr !== prog[0]) begin n_err++; $display("FAIL restart_word0 got=%b/%b exp=1/%b", instr_valid, instr, prog[0]); end
`endif
  endtask

  task automatic test_fill();
    int low_cnt = 0;
    for (int i = 0; i < 16; i++) prog[i] = 6'($urandom);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (load_ready !== 1'b1) low_cnt++;
      load_valid = 1; load_data = prog[i];
      step();
    end
    n_cmp++; if (low_cnt !== 0) begin n_err++; $display("FAIL fill_throughput got=%0d stalls exp=0", low_cnt); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got=%b exp=0", load_ready); end
    n_cmp++; if (prog_len !== 5'd16) begin n_err++; $display("FAIL fill_len got=%0d exp=16", prog_len); end
    load_data = ~prog[0];
    step();
    load_valid = 0;
    n_cmp++; if (prog_len !== 5'd16) begin n_err++; $display("FAIL fill_17th got=%0d exp=16", prog_len); end
    kick();
    run_issue(18, -1, 4'd0);
    n_cmp++; if (got.size() !== (LOOP ? 18 : 16)) begin n_err++; $display("FAIL fill_count got=%0d exp=%0d", got.size(), LOOP ? 18 : 16); end
    for (int i = 0; i < got.size() && i < 18; i++) begin
      n_cmp++; if (got[i] !== prog[i % 16]) begin n_err++; $display("FAIL fill_word%0d got=%b exp=%b", i, got[i], prog[i % 16]); end
    end
    n_cmp++; if (done !== !LOOP) begin n_err++; $display("FAIL fill_done got=%b exp=%b", done, !LOOP); end
  endtask

  task automatic test_redirect();
    int exp_a [$];
    for (int i = 0; i < 6; i++) prog[i] = 6'(8 * i + 5);
    for (int pass = 0; pass < 2; pass++) begin
`ifdef FEEDER_LOOP_EN
      if (pass == 0) exp_a = '{0,1,2,3,1,2,3,4,5,0,1,2,3,4};
      else           exp_a = '{0,1,2,3,0,1,2,3,4,5,0,1,2,3};
`else
      if (pass == 0) exp_a = '{0,1,2,3,1,2,3,4,5};
      else           exp_a = '{0,1,2,3};
`endif
      do_reset();
      load_words(6, 0);
      kick();
      run_issue(14, 3, (pass == 0) ? 4'd1 : 4'd7);
      n_cmp++; if (got.size() !== exp_a.size()) begin n_err++; $display("FAIL redir%0d_count got=%0d exp=%0d", pass, got.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < got.size(); i++) begin
        n_cmp++; if (got[i] !== prog[exp_a[i]]) begin n_err++; $display("FAIL redir%0d_word%0d got=%b exp=%b", pass, i, got[i], prog[exp_a[i]]); end
      end
      n_cmp++; if (done !== !LOOP) begin n_err++; $display("FAIL redir%0d_done got=%b exp=%b", pass, done, !LOOP); end
    end
  endtask

  task automatic test_halt_clear();
    logic [3:0] pc_b;
    for (int i = 0; i < 6; i++) prog[i] = 6'(63 - 7 * i);
    do_reset();
    load_words(6, 0);
    kick();
    got.delete();
    for (int c = 0; c < 12; c++) begin
      halt = (c >= 2 && c < 5);
      pc_b = pc;
      step();
      if (halt) begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid c%0d got=%b exp=0", c, instr_valid); end
        n_cmp++; if (pc !== pc_b) begin n_err++; $display("FAIL halt_pc c%0d got=%0d exp=%0d", c, pc, pc_b); end
      end else if (instr_valid) begin
        got.push_back(instr);
      end
    end
    halt = 0;
    n_cmp++; if (got.size() !== (LOOP ? 9 : 6)) begin n_err++; $display("FAIL halt_count got=%0d exp=%0d", got.size(), LOOP ? 9 : 6); end
    for (int i = 0; i < got.size() && i < 9; i++) begin
      n_cmp++; if (got[i] !== prog[i % 6]) begin n_err++; $display("FAIL halt_word%0d got=%b exp=%b", i, got[i], prog[i % 6]); end
    end
    // Clear in the middle of a run.
    do_reset();
    load_words(6, 0);
    kick();
    step();
    step();
    clear = 1;
    step();
    clear = 0;
    n_cmp++; if (prog_len !== 5'd0) begin n_err++; $display("FAIL clear_len got=%0d exp=0", prog_len); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL clear_state got=busy%b done%b exp=00", busy, done); end
    n_cmp++; if (instr_valid !== 1'b0 || instr !== 6'h00) begin n_err++; $display("FAIL clear_instr got=%b/%b exp=0/000000", instr_valid, instr); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL clear_ready got=%b exp=1", load_ready); end
  endtask

`ifdef FEEDER_LOOP_EN
  task automatic test_loop();
    for (int i = 0; i < 3; i++) prog[i] = 6'(11 * i + 3);
    do_reset();
    load_words(3, 0);
    kick();
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++; if (instr_valid !== 1'b1 || instr !== prog[c % 3] || done !== 1'b0) begin
        n_err++; $display("FAIL loop_c%0d got=%b/%b done=%b exp=1/%b done=0", c, instr_valid, instr, done, prog[c % 3]);
      end
    end
  endtask
`endif

  // Randomized replay: the model walks the program address by address using the issue rules.
  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int len, addr, cyc, a;
      bit same, run, h, r;
      len = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) prog[i] = 6'($urandom);
      do_reset();
      same = 1'($urandom_range(0, 1));
      load_words(len, same);
      if (!same) kick();
      n_cmp++; if (busy !== 1'b1 || pc !== 4'd0 || prog_len !== 5'(len)) begin
        n_err++; $display("FAIL rnd%0d_start got=busy%b pc%0d len%0d exp=busy1 pc0 len%0d", it, busy, pc, prog_len, len);
      end
      addr = 0; run = 1; cyc = 0;
      while (run && cyc < 80) begin
        h = (cyc < 40) && ($urandom_range(0, 3) == 0);
        r = (cyc < 40) && ($urandom_range(0, 4) == 0);
        a = $urandom_range(0, 15);
        halt = h; redirect_valid = r; redirect_addr = a[3:0];
        step();
        if (h) begin
          n_cmp++; if (instr_valid !== 1'b0 || pc !== addr[3:0]) begin
            n_err++; $display("FAIL rnd%0d_halt c%0d got=v%b pc%0d exp=v0 pc%0d", it, cyc, instr_valid, pc, addr);
          end
        end else begin
          n_cmp++; if (instr_valid !== 1'b1 || instr !== prog[addr]) begin
            n_err++; $display("FAIL rnd%0d_issue c%0d got=%b/%b exp=1/%b", it, cyc, instr_valid, instr, prog[addr]);
          end
          if (r && a < len) addr = a;
          else if (r || addr == len - 1) begin
            if (LOOP) addr = 0;
            else run = 0;
          end else addr = addr + 1;
          if (run) begin
            n_cmp++; if (pc !== addr[3:0] || busy !== 1'b1) begin
              n_err++; $display("FAIL rnd%0d_pc c%0d got=%0d busy%b exp=%0d busy1", it, cyc, pc, busy, addr);
            end
          end
        end
        cyc++;
      end
      halt = 0; redirect_valid = 0;
      if (!LOOP) begin
        n_cmp++;
        if (run) begin
          n_err++; $display("FAIL rnd%0d_timeout got=running exp=done within 80 cycles", it);
        end else begin
          step();
          if (done !== 1'b1 || instr_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rnd%0d_end got=done%b v%b busy%b exp=done1 v0 busy0", it, done, instr_valid, busy);
          end
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_replay();
    test_fill();
    test_redirect();
    test_halt_clear();
`ifdef FEEDER_LOOP_EN
    test_loop();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
